rpn_stack_alu: RTL and testbench

RPN_STACK_ALU -- requirements
Module: rpn_stack_alu

---
 rtl/rpn_stack_alu_if.sv | 27 ++
 rtl/rpn_stack_alu.sv | 159 +++++++++++++++
 tb/tb_rpn_stack_alu.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/rpn_stack_alu_if.sv
// Command/status bundle for the RPN stack calculator.
// master: drives Value and the one-cycle command pulses, observes the status outputs.
// slave : the calculator core; consumes the commands and drives Top/DispEn/Depth/Busy/Err/Ovf.
interface rpn_stack_alu_if;
  logic signed [7:0] Value;   // operand from switches, sampled on a push
  logic              PushP;   // command pulses, one cycle each
  logic              PopP;
  logic              AddP;
  logic              SubP;
  logic              MulP;
  logic signed [7:0] Top;     // stack entry 0, 0 when empty
  logic              DispEn;  // stack not empty
  logic [2:0]        Depth;   // valid entries, 0..4
  logic              Busy;    // multiply in progress
  logic              Err;     // last command rejected
  logic              Ovf;     // last arithmetic result out of range

  modport master (
    output Value, PushP, PopP, AddP, SubP, MulP,
    input  Top, DispEn, Depth, Busy, Err, Ovf
  );

  modport slave (
    input  Value, PushP, PopP, AddP, SubP, MulP,
    output Top, DispEn, Depth, Busy, Err, Ovf
  );
endinterface

// File: rtl/rpn_stack_alu.sv
// Four-entry signed 8-bit RPN calculator: push/pop/add/sub single-cycle, multiply by
// 8-cycle shift-add plus one writeback cycle (Busy for 9 cycles), wrap-around results.
// Ports: Clock, Reset_n (sync, active-low), bus (slave modport: Value, command pulses in;
// Top, DispEn, Depth, Busy, Err, Ovf out). Commands arriving while Busy are dropped.
module rpn_stack_alu (
  input  logic              Clock,
  input  logic              Reset_n,
  rpn_stack_alu_if.slave    bus
);

  typedef enum logic [1:0] {IDLE, MUL, WB} state_t;

  state_t            state_q, state_d;
  logic [3:0][7:0]   ent_q, ent_d;      // ent[0] = top of stack
  logic [2:0]        depth_q, depth_d;
  logic              err_q, err_d;
  logic              ovf_q, ovf_d;
  logic [15:0]       acc_q, acc_d;      // product magnitude accumulator
  logic [15:0]       mcand_q, mcand_d;  // multiplicand magnitude, shifted left each step
  logic [7:0]        mplier_q, mplier_d;// multiplier magnitude, shifted right each step
  logic [2:0]        cnt_q, cnt_d;
  logic              neg_q, neg_d;      // operand signs differ

  logic [4:0]        cmd;
  logic              multi;
  logic [8:0]        sum9, diff9;
  logic [7:0]        mag0, mag1;
  logic signed [15:0] prod_s;
  logic              prod_ovf;

  assign cmd   = {bus.PushP, bus.PopP, bus.AddP, bus.SubP, bus.MulP};
  // Clearing the lowest set bit leaves something only if two or more pulses are high.
  assign multi = (cmd & (cmd - 5'd1)) != 5'd0;

  // Sign-extended 9-bit arithmetic; overflow when the two top bits disagree.
  assign sum9  = {ent_q[1][7], ent_q[1]} + {ent_q[0][7], ent_q[0]};
  assign diff9 = {ent_q[1][7], ent_q[1]} - {ent_q[0][7], ent_q[0]};

  // 8-bit unsigned magnitudes so -128 becomes 128 rather than overflowing.
  assign mag0 = ent_q[0][7] ? 8'(~ent_q[0] + 8'd1) : ent_q[0];
  assign mag1 = ent_q[1][7] ? 8'(~ent_q[1] + 8'd1) : ent_q[1];

  // Magnitude is at most 16384, so a 16-bit signed result cannot wrap.
  assign prod_s   = neg_q ? -$signed(acc_q) : $signed(acc_q);
  assign prod_ovf = (prod_s > 16'sd127) || (prod_s < -16'sd128);

  always_comb begin
    state_d  = state_q;
    ent_d    = ent_q;
    depth_d  = depth_q;
    err_d    = err_q;
    ovf_d    = ovf_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;

    case (state_q)
      IDLE: begin
        if (cmd != 5'd0) begin
          // Assume rejection; each accepted branch overrides err_d/ovf_d.
          err_d = 1'b1;
          ovf_d = 1'b0;
          if (!multi) begin
            if (bus.PushP) begin
              if (depth_q != 3'd4) begin
                ent_d   = {ent_q[2:0], bus.Value};
                depth_d = depth_q + 3'd1;
                err_d   = 1'b0;
              end
            end else if (bus.PopP) begin
              if (depth_q != 3'd0) begin
                ent_d   = {8'h00, ent_q[3:1]};
                depth_d = depth_q - 3'd1;
                err_d   = 1'b0;
              end
            end else if (depth_q >= 3'd2) begin
              err_d = 1'b0;
              if (bus.AddP) begin
                ent_d   = {8'h00, ent_q[3:2], sum9[7:0]};
                depth_d = depth_q - 3'd1;
                ovf_d   = sum9[8] ^ sum9[7];
              end else if (bus.SubP) begin
                ent_d   = {8'h00, ent_q[3:2], diff9[7:0]};
                depth_d = depth_q - 3'd1;
                ovf_d   = diff9[8] ^ diff9[7];
              end else begin
                // Multiply: latch magnitudes and sign; stack stays frozen until WB.
                state_d  = MUL;
                acc_d    = 16'd0;
                mcand_d  = {8'h00, mag0};
                mplier_d = mag1;
                cnt_d    = 3'd0;
                neg_d    = ent_q[0][7] ^ ent_q[1][7];
              end
            end
          end
        end
      end

      MUL: begin
        if (mplier_q[0]) begin
          acc_d = acc_q + mcand_q;
        end
        mcand_d  = {mcand_q[14:0], 1'b0};
        mplier_d = {1'b0, mplier_q[7:1]};
        cnt_d    = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          state_d = WB;
        end
      end

      WB: begin
        ent_d   = {8'h00, ent_q[3:2], prod_s[7:0]};
        depth_d = depth_q - 3'd1;
        ovf_d   = prod_ovf;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      state_q  <= IDLE;
      ent_q    <= '0;
      depth_q  <= 3'd0;
      err_q    <= 1'b0;
      ovf_q    <= 1'b0;
      acc_q    <= 16'd0;
      mcand_q  <= 16'd0;
      mplier_q <= 8'd0;
      cnt_q    <= 3'd0;
      neg_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ent_q    <= ent_d;
      depth_q  <= depth_d;
      err_q    <= err_d;
      ovf_q    <= ovf_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
    end
  end

  // Status outputs come straight from registers.
  assign bus.Top    = (depth_q == 3'd0) ? 8'sd0 : $signed(ent_q[0]);
  assign bus.DispEn = (depth_q != 3'd0);
  assign bus.Depth  = depth_q;
  assign bus.Busy   = (state_q != IDLE);
  assign bus.Err    = err_q;
  assign bus.Ovf    = ovf_q;

endmodule

// File: tb/tb_rpn_stack_alu.sv
module tb_rpn_stack_alu;

  localparam logic [4:0] C_PUSH = 5'b10000;
  localparam logic [4:0] C_POP  = 5'b01000;
  localparam logic [4:0] C_ADD  = 5'b00100;
  localparam logic [4:0] C_SUB  = 5'b00010;
  localparam logic [4:0] C_MUL  = 5'b00001;

  logic Clock;
  logic Reset_n;
  int   n_cmp;
  int   n_err;

  rpn_stack_alu_if bus ();

  rpn_stack_alu dut (
    .Clock   (Clock),
    .Reset_n (Reset_n),
    .bus     (bus)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Drive one command at the falling edge, let it be taken at the rising edge,
  // then release it; outputs are then stable 1 ns after that edge.
  task automatic pulse(input logic [4:0] c, input logic [7:0] v);
    @(negedge Clock);
    bus.Value = v;
    {bus.PushP, bus.PopP, bus.AddP, bus.SubP, bus.MulP} = c;
    @(posedge Clock);
    #1;
    {bus.PushP, bus.PopP, bus.AddP, bus.SubP, bus.MulP} = 5'b00000;
  endtask

  task automatic do_reset();
    @(negedge Clock);
    Reset_n = 1'b0;
    @(posedge Clock);
    @(posedge Clock);
    #1;
    @(negedge Clock);
    Reset_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge Clock);
    Reset_n = 1'b0;
    @(posedge Clock);
    #1;
    n_cmp++; if (bus.Top !== 8'h00) begin n_err++; $display("FAIL rst_top: got %h want 00", bus.Top); end
    n_cmp++; if (bus.Depth !== 3'd0) begin n_err++; $display("FAIL rst_depth: got %0d want 0", bus.Depth); end
    n_cmp++; if ({bus.DispEn, bus.Busy, bus.Err, bus.Ovf} !== 4'b0000) begin n_err++; $display("FAIL rst_flags: got %b want 0000", {bus.DispEn, bus.Busy, bus.Err, bus.Ovf}); end
    @(negedge Clock);
    Reset_n = 1'b1;
    // Command on the very first edge after release, and arithmetic on too-shallow stack.
    pulse(C_ADD, 8'h00);
    n_cmp++; if (bus.Err !== 1'b1) begin n_err++; $display("FAIL add_empty_err: got %b want 1", bus.Err); end
    pulse(C_PUSH, 8'h2A);
    n_cmp++; if (bus.Top !== 8'h2A || bus.Depth !== 3'd1 || bus.Err !== 1'b0) begin n_err++; $display("FAIL first_push: got top %h depth %0d err %b want 2a 1 0", bus.Top, bus.Depth, bus.Err); end
    pulse(C_MUL, 8'h00);
    n_cmp++; if (bus.Err !== 1'b1 || bus.Busy !== 1'b0 || bus.Depth !== 3'd1) begin n_err++; $display("FAIL mul_shallow: got err %b busy %b depth %0d want 1 0 1", bus.Err, bus.Busy, bus.Depth); end
  endtask

  task automatic test_sub();
    do_reset();
    pulse(C_PUSH, 8'h05);
    pulse(C_PUSH, 8'hFD);
    pulse(C_SUB, 8'h00);
    n_cmp++; if (bus.Top !== 8'h08) begin n_err++; $display("FAIL sub_top: got %h want 08", bus.Top); end
    n_cmp++; if (bus.Depth !== 3'd1 || bus.Err !== 1'b0 || bus.Ovf !== 1'b0) begin n_err++; $display("FAIL sub_state: got depth %0d err %b ovf %b want 1 0 0", bus.Depth, bus.Err, bus.Ovf); end
    pulse(C_POP, 8'h00);
    n_cmp++; if (bus.Depth !== 3'd0 || bus.Top !== 8'h00 || bus.DispEn !== 1'b0) begin n_err++; $display("FAIL sub_pop: got depth %0d top %h dispen %b want 0 00 0", bus.Depth, bus.Top, bus.DispEn); end
  endtask

  task automatic test_add_ovf();
    do_reset();
    pulse(C_PUSH, 8'd100);
    pulse(C_PUSH, 8'd100);
    n_cmp++; if (bus.DispEn !== 1'b1 || bus.Depth !== 3'd2) begin n_err++; $display("FAIL add_pre: got dispen %b depth %0d want 1 2", bus.DispEn, bus.Depth); end
    pulse(C_ADD, 8'h00);
    n_cmp++; if (bus.Top !== 8'hC8 || bus.Ovf !== 1'b1 || bus.Depth !== 3'd1) begin n_err++; $display("FAIL add_ovf: got top %h ovf %b depth %0d want c8 1 1", bus.Top, bus.Ovf, bus.Depth); end
    pulse(C_POP, 8'h00);
    n_cmp++; if (bus.Ovf !== 1'b0 || bus.Depth !== 3'd0) begin n_err++; $display("FAIL pop_clr_ovf: got ovf %b depth %0d want 0 0", bus.Ovf, bus.Depth); end
    pulse(C_POP, 8'h00);
    n_cmp++; if (bus.Err !== 1'b1 || bus.Depth !== 3'd0) begin n_err++; $display("FAIL pop_empty: got err %b depth %0d want 1 0", bus.Err, bus.Depth); end
  endtask

  task automatic test_mul();
    int cyc;
    do_reset();
    pulse(C_PUSH, 8'hF4);
    pulse(C_PUSH, 8'h0A);
    pulse(C_MUL, 8'h00);
    cyc = 0;
    while (bus.Busy === 1'b1 && cyc < 20) begin
      cyc++;
      @(posedge Clock);
      #1;
    end
    n_cmp++; if (cyc !== 9) begin n_err++; $display("FAIL mul_busy_cycles: got %0d want 9", cyc); end
    n_cmp++; if (bus.Top !== 8'h88 || bus.Ovf !== 1'b0 || bus.Depth !== 3'd1) begin n_err++; $display("FAIL mul_result: got top %h ovf %b depth %0d want 88 0 1", bus.Top, bus.Ovf, bus.Depth); end
  endtask

  task automatic test_mul_ovf_busy();
    int cyc;
    do_reset();
    pulse(C_PUSH, 8'h10);
    pulse(C_PUSH, 8'h10);
    pulse(C_MUL, 8'h00);
    // Pushes while busy must be dropped silently.
    pulse(C_PUSH, 8'h33);
    pulse(C_PUSH, 8'h44);
    n_cmp++; if (bus.Busy !== 1'b1 || bus.Err !== 1'b0 || bus.Depth !== 3'd2 || bus.Top !== 8'h10) begin n_err++; $display("FAIL busy_frozen: got busy %b err %b depth %0d top %h want 1 0 2 10", bus.Busy, bus.Err, bus.Depth, bus.Top); end
    cyc = 0;
    while (bus.Busy === 1'b1 && cyc < 20) begin
      cyc++;
      @(posedge Clock);
      #1;
    end
    n_cmp++; if (cyc >= 20) begin n_err++; $display("FAIL mul16_timeout: got %0d cycles want < 20", cyc); end
    n_cmp++; if (bus.Top !== 8'h00 || bus.Ovf !== 1'b1 || bus.Depth !== 3'd1 || bus.Err !== 1'b0) begin n_err++; $display("FAIL mul16: got top %h ovf %b depth %0d err %b want 00 1 1 0", bus.Top, bus.Ovf, bus.Depth, bus.Err); end

    // -128 * 1 = -128, representable.
    do_reset();
    pulse(C_PUSH, 8'h80);
    pulse(C_PUSH, 8'h01);
    pulse(C_MUL, 8'h00);
    repeat (9) @(posedge Clock);
    #1;
    n_cmp++; if (bus.Top !== 8'h80 || bus.Ovf !== 1'b0 || bus.Busy !== 1'b0) begin n_err++; $display("FAIL mul_m128x1: got top %h ovf %b busy %b want 80 0 0", bus.Top, bus.Ovf, bus.Busy); end

    // -128 * -1 = +128 overflows and wraps to -128.
    do_reset();
    pulse(C_PUSH, 8'h80);
    pulse(C_PUSH, 8'hFF);
    pulse(C_MUL, 8'h00);
    repeat (9) @(posedge Clock);
    #1;
    n_cmp++; if (bus.Top !== 8'h80 || bus.Ovf !== 1'b1 || bus.Depth !== 3'd1) begin n_err++; $display("FAIL mul_m128xm1: got top %h ovf %b depth %0d want 80 1 1", bus.Top, bus.Ovf, bus.Depth); end
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 1; i <= 4; i++) pulse(C_PUSH, 8'(i));
    pulse(C_PUSH, 8'h05);
    n_cmp++; if (bus.Err !== 1'b1 || bus.Depth !== 3'd4 || bus.Top !== 8'h04) begin n_err++; $display("FAIL push_full: got err %b depth %0d top %h want 1 4 04", bus.Err, bus.Depth, bus.Top); end
    pulse(C_POP | C_PUSH, 8'h09);
    n_cmp++; if (bus.Err !== 1'b1 || bus.Depth !== 3'd4 || bus.Top !== 8'h04 || bus.Ovf !== 1'b0) begin n_err++; $display("FAIL multi_cmd: got err %b depth %0d top %h ovf %b want 1 4 04 0", bus.Err, bus.Depth, bus.Top, bus.Ovf); end
    pulse(C_POP, 8'h00);
    n_cmp++; if (bus.Err !== 1'b0 || bus.Depth !== 3'd3 || bus.Top !== 8'h03) begin n_err++; $display("FAIL pop_after_full: got err %b depth %0d top %h want 0 3 03", bus.Err, bus.Depth, bus.Top); end
    pulse(C_SUB, 8'h00);
    n_cmp++; if (bus.Top !== 8'hFF || bus.Depth !== 3'd2 || bus.Ovf !== 1'b0) begin n_err++; $display("FAIL sub_neg: got top %h depth %0d ovf %b want ff 2 0", bus.Top, bus.Depth, bus.Ovf); end
  endtask

  task automatic test_reset_mid_mul();
    do_reset();
    pulse(C_PUSH, 8'h03);
    pulse(C_PUSH, 8'h04);
    pulse(C_MUL, 8'h00);
    repeat (3) @(posedge Clock);
    @(negedge Clock);
    Reset_n = 1'b0;
    @(posedge Clock);
    #1;
    n_cmp++; if (bus.Top !== 8'h00 || bus.Depth !== 3'd0 || {bus.DispEn, bus.Busy, bus.Err, bus.Ovf} !== 4'b0000) begin n_err++; $display("FAIL rst_mid_mul: got top %h depth %0d flags %b want 00 0 0000", bus.Top, bus.Depth, {bus.DispEn, bus.Busy, bus.Err, bus.Ovf}); end
    @(negedge Clock);
    Reset_n = 1'b1;
    pulse(C_PUSH, 8'h07);
    n_cmp++; if (bus.Top !== 8'h07 || bus.Depth !== 3'd1) begin n_err++; $display("FAIL push_after_rst: got top %h depth %0d want 07 1", bus.Top, bus.Depth); end
    repeat (12) @(posedge Clock);
    #1;
    n_cmp++; if (bus.Top !== 8'h07 || bus.Depth !== 3'd1 || bus.Busy !== 1'b0) begin n_err++; $display("FAIL no_late_wb: got top %h depth %0d busy %b want 07 1 0", bus.Top, bus.Depth, bus.Busy); end
  endtask

  initial begin
    n_cmp   = 0;
    n_err   = 0;
    Reset_n = 1'b0;
    bus.Value = 8'h00;
    {bus.PushP, bus.PopP, bus.AddP, bus.SubP, bus.MulP} = 5'b00000;

    test_reset();
    test_sub();
    test_add_ovf();
    test_mul();
    test_mul_ovf_busy();
    test_full();
    test_reset_mid_mul();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
